// File: rtl/poly_note_player.sv
// Polyphonic note player: per-voice phase accumulators with beat-timed note
// lengths, mixed into one signed sample by a voice-serial accumulator FSM.
module poly_note_player #(
  parameter int VOICES   = 4,
  parameter int PHASE_W  = 20,
  parameter int DUR_W    = 6,
  parameter int SAMPLE_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        play_enable,
  input  logic                        load_new_note,
  input  logic [$clog2(VOICES)-1:0]   load_voice,
  input  logic [PHASE_W-1:0]          step_to_load,
  input  logic [DUR_W-1:0]            duration_to_load,
  input  logic [1:0]                  wave_to_load,
  input  logic                        beat,
  input  logic                        generate_next_sample,
  output logic [VOICES-1:0]           voice_busy,
  output logic [VOICES-1:0]           done_with_note,
  output logic signed [SAMPLE_W-1:0]  sample_out,
  output logic                        new_sample_ready
);

  localparam int IDX_W = $clog2(VOICES);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam logic signed [SAMPLE_W-1:0] SQ_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [SAMPLE_W-1:0]       sample_q, sample_d;
  logic                      nsr_q, nsr_d;
  logic [VOICES-1:0]         done_q, done_d;
  logic [VOICES-1:0]         active_q, active_d;
  logic [PHASE_W-1:0]        phase_q [VOICES];
  logic [PHASE_W-1:0]        phase_d [VOICES];
  logic [PHASE_W-1:0]        step_q [VOICES];
  logic [PHASE_W-1:0]        step_d [VOICES];
  logic [DUR_W-1:0]          remaining_q [VOICES];
  logic [DUR_W-1:0]          remaining_d [VOICES];
  logic [1:0]                wave_q [VOICES];
  logic [1:0]                wave_d [VOICES];

  logic [SAMPLE_W-1:0]       p;
  logic [SAMPLE_W-2:0]       tri_t;
  logic signed [SAMPLE_W-1:0] contrib;
  logic                      visiting;

  assign visiting = (state_q == ACCUM) && play_enable;

  // Waveform value of the voice currently being visited, taken from its pre-advance phase
  always_comb begin
    p       = phase_q[idx_q][PHASE_W-1 -: SAMPLE_W];
    tri_t   = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
    contrib = '0;
    case (wave_q[idx_q])
      2'b00:   contrib = p[SAMPLE_W-1] ? -SQ_MAX : SQ_MAX;
      2'b01:   contrib = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
      2'b10:   contrib = {~tri_t[SAMPLE_W-2], tri_t[SAMPLE_W-3:0], 1'b0};
      default: contrib = '0;
    endcase
    if (!active_q[idx_q] || (step_q[idx_q] == '0))
      contrib = '0;
  end

  // Voice state: phase advance, then beat countdown, then load (load has final say)
  always_comb begin
    phase_d     = phase_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    wave_d      = wave_q;
    active_d    = active_q;
    done_d      = '0;

    if (visiting && active_q[idx_q])
      phase_d[idx_q] = phase_q[idx_q] + step_q[idx_q];

    if (beat && play_enable) begin
      for (int v = 0; v < VOICES; v++) begin
        if (active_q[v]) begin
          remaining_d[v] = remaining_q[v] - DUR_W'(1);
          if (remaining_q[v] == DUR_W'(1)) begin
            active_d[v] = 1'b0;
            done_d[v]   = 1'b1;
          end
        end
      end
    end

    if (load_new_note) begin
      phase_d[load_voice]     = '0;
      step_d[load_voice]      = step_to_load;
      wave_d[load_voice]      = wave_to_load;
      remaining_d[load_voice] = duration_to_load;
      active_d[load_voice]    = (duration_to_load != '0);
      done_d[load_voice]      = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    nsr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (generate_next_sample && play_enable) begin
          state_d = ACCUM;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        if (play_enable) begin
          acc_d = acc_q + {{IDX_W{contrib[SAMPLE_W-1]}}, contrib};
          if (idx_q == IDX_W'(VOICES - 1))
            state_d = OUT;
          else
            idx_d = idx_q + IDX_W'(1);
        end
      end
      OUT: begin
        sample_d = SAMPLE_W'(acc_q >>> IDX_W);
        nsr_d    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      nsr_q    <= 1'b0;
      done_q   <= '0;
      active_q <= '0;
      for (int v = 0; v < VOICES; v++) begin
        phase_q[v]     <= '0;
        step_q[v]      <= '0;
        remaining_q[v] <= '0;
        wave_q[v]      <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      nsr_q       <= nsr_d;
      done_q      <= done_d;
      active_q    <= active_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      wave_q      <= wave_d;
    end
  end

  assign voice_busy       = active_q;
  assign done_with_note   = done_q;
  assign sample_out       = sample_q;
  assign new_sample_ready = nsr_q;

endmodule

// File: tb/tb_poly_note_player.sv
// Randomized bench for poly_note_player: directed scenarios followed by random
// loads, beats and sample requests, all checked against a transaction-level model.
module tb_poly_note_player;

  localparam int VOICES   = 4;
  localparam int PHASE_W  = 20;
  localparam int DUR_W    = 6;
  localparam int SAMPLE_W = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                play_enable = 1'b0;
  logic                load_new_note = 1'b0;
  logic [1:0]          load_voice = '0;
  logic [PHASE_W-1:0]  step_to_load = '0;
  logic [DUR_W-1:0]    duration_to_load = '0;
  logic [1:0]          wave_to_load = '0;
  logic                beat = 1'b0;
  logic                generate_next_sample = 1'b0;
  logic [VOICES-1:0]   voice_busy;
  logic [VOICES-1:0]   done_with_note;
  logic [SAMPLE_W-1:0] sample_out;
  logic                new_sample_ready;

  int checks = 0;
  int errors = 0;

  int m_phase [VOICES];
  int m_step  [VOICES];
  int m_rem   [VOICES];
  int m_wave  [VOICES];
  bit m_active [VOICES];
  int m_sample;

  poly_note_player #(
    .VOICES(VOICES), .PHASE_W(PHASE_W), .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W)
  ) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable),
    .load_new_note(load_new_note), .load_voice(load_voice),
    .step_to_load(step_to_load), .duration_to_load(duration_to_load),
    .wave_to_load(wave_to_load), .beat(beat),
    .generate_next_sample(generate_next_sample),
    .voice_busy(voice_busy), .done_with_note(done_with_note),
    .sample_out(sample_out), .new_sample_ready(new_sample_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: behaviour of one note per voice, computed with plain integer arithmetic
  function automatic int waveValue(input int w, input int ph);
    int p;
    p = ph / (1 << (PHASE_W - SAMPLE_W));
    case (w)
      0: return (p < 32768) ? 32767 : -32767;
      1: return p - 32768;
      2: return (p < 32768) ? (2 * p - 32768) : (2 * (65535 - p) - 32768);
      default: return 0;
    endcase
  endfunction

  function automatic void modelReset();
    for (int v = 0; v < VOICES; v++) begin
      m_phase[v] = 0; m_step[v] = 0; m_rem[v] = 0; m_wave[v] = 0; m_active[v] = 0;
    end
    m_sample = 0;
  endfunction

  function automatic void modelSample();
    int sum;
    sum = 0;
    for (int v = 0; v < VOICES; v++) begin
      if (m_active[v] && m_step[v] != 0 && m_wave[v] != 3)
        sum += waveValue(m_wave[v], m_phase[v]);
      if (m_active[v])
        m_phase[v] = (m_phase[v] + m_step[v]) % (1 << PHASE_W);
    end
    m_sample = (sum >= 0) ? sum / VOICES : -((-sum + VOICES - 1) / VOICES);
  endfunction

  function automatic logic [VOICES-1:0] modelBeat(input int skip);
    logic [VOICES-1:0] d;
    d = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (m_active[v] && v != skip) begin
        m_rem[v]--;
        if (m_rem[v] == 0) begin
          m_active[v] = 0;
          d[v] = 1'b1;
        end
      end
    end
    return d;
  endfunction

  function automatic void modelLoad(input int v, input int st, input int dur, input int w);
    m_phase[v] = 0; m_step[v] = st; m_rem[v] = dur; m_wave[v] = w; m_active[v] = (dur != 0);
  endfunction

  function automatic logic [VOICES-1:0] busyExp();
    logic [VOICES-1:0] b;
    for (int v = 0; v < VOICES; v++) b[v] = m_active[v];
    return b;
  endfunction

  task automatic doReset(input string tag);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput({tag, "_busy"}, voice_busy, '0);
    checkOutput({tag, "_done"}, done_with_note, '0);
    checkOutput({tag, "_sample"}, sample_out, '0);
    checkOutput({tag, "_nsr"}, new_sample_ready, 0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic doLoad(input int v, input int st, input int dur, input int w, input bit withBeat);
    logic [VOICES-1:0] dExp;
    load_new_note = 1'b1;
    load_voice = 2'(v);
    step_to_load = PHASE_W'(st);
    duration_to_load = DUR_W'(dur);
    wave_to_load = 2'(w);
    beat = withBeat;
    tick();
    load_new_note = 1'b0;
    beat = 1'b0;
    dExp = (withBeat && play_enable) ? modelBeat(v) : '0;
    modelLoad(v, st, dur, w);
    checkOutput("load_done", done_with_note, dExp);
    checkOutput("load_busy", voice_busy, busyExp());
  endtask

  task automatic doBeat();
    logic [VOICES-1:0] dExp;
    beat = 1'b1;
    tick();
    beat = 1'b0;
    dExp = play_enable ? modelBeat(-1) : '0;
    checkOutput("beat_done", done_with_note, dExp);
    checkOutput("beat_busy", voice_busy, busyExp());
  endtask

  // Request a sample; optional pause window (edges after the request) or a load landing on the visited voice
  task automatic doRequest(input int pauseAt, input int pauseLen, input int midVoice,
                           input int st, input int dur, input int w);
    int lat;
    bit seen;
    if (!play_enable) begin
      seen = 0;
      generate_next_sample = 1'b1;
      tick();
      generate_next_sample = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (new_sample_ready) seen = 1;
        tick();
      end
      checkOutput("ignored_req_nsr", seen, 0);
      checkOutput("ignored_req_hold", sample_out, 32'(m_sample) & 32'hFFFF);
      return;
    end
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    modelSample();
    lat = 0;
    while (!new_sample_ready && lat < 40) begin
      play_enable = !((lat + 1) >= pauseAt && (lat + 1) < pauseAt + pauseLen);
      if (midVoice >= 0 && (lat + 1) == midVoice + 1) begin
        load_new_note = 1'b1;
        load_voice = 2'(midVoice);
        step_to_load = PHASE_W'(st);
        duration_to_load = DUR_W'(dur);
        wave_to_load = 2'(w);
      end
      tick();
      load_new_note = 1'b0;
      lat++;
    end
    play_enable = 1'b1;
    if (midVoice >= 0) modelLoad(midVoice, st, dur, w);
    checkOutput("req_latency", lat, VOICES + 1 + pauseLen);
    checkOutput("req_sample", sample_out, 32'(m_sample) & 32'hFFFF);
    tick();
    checkOutput("req_pulse_end", new_sample_ready, 0);
    if (midVoice >= 0) checkOutput("midload_busy", voice_busy, busyExp());
  endtask

  task automatic applyStimulus(input int op);
    int v, st, dur, w;
    v   = $urandom_range(0, VOICES - 1);
    st  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, (1 << PHASE_W) - 1));
    dur = $urandom_range(0, 4);
    w   = $urandom_range(0, 3);
    case (op)
      0, 1, 2: doLoad(v, st, dur, w, 1'b0);
      3:       doLoad(v, st, dur, w, 1'b1);
      4, 5:    doBeat();
      6:       doRequest(0, 0, -1, 0, 0, 0);
      7:       doRequest($urandom_range(1, VOICES), $urandom_range(1, 3), -1, 0, 0, 0);
      8: begin
        play_enable = 1'b0;
        case ($urandom_range(0, 2))
          0: doBeat();
          1: doRequest(0, 0, -1, 0, 0, 0);
          default: doLoad(v, st, dur, w, 1'b0);
        endcase
        play_enable = 1'b1;
      end
      default: doRequest(0, 0, v, st, dur, w);
    endcase
  endtask

  initial begin
    logic [VOICES-1:0] dExp;
    bit seen;
    modelReset();
    tick();
    doReset("reset");
    play_enable = 1'b1;

    doRequest(0, 0, -1, 0, 0, 0);
    checkOutput("empty_sample", sample_out, 16'h0000);

    doLoad(0, 20'h10000, 2, 1, 1'b0);
    doRequest(0, 0, -1, 0, 0, 0);
    checkOutput("saw_first", sample_out, 16'hE000);
    doRequest(0, 0, -1, 0, 0, 0);
    checkOutput("saw_second", sample_out, 16'hE400);
    doBeat();
    doBeat();
    checkOutput("saw_expire_done", done_with_note, 4'b0001);
    checkOutput("saw_expire_busy", voice_busy[0], 0);
    tick();
    checkOutput("done_one_cycle", done_with_note, 4'b0000);
    doRequest(0, 0, -1, 0, 0, 0);
    checkOutput("after_expire", sample_out, 16'h0000);

    doReset("reset2");
    play_enable = 1'b1;
    doLoad(0, 20'h100, 5, 0, 1'b0);
    doLoad(1, 20'h100, 5, 0, 1'b0);
    doRequest(0, 0, -1, 0, 0, 0);
    checkOutput("square_pair", sample_out, 16'h3FFF);

    doLoad(2, 20'h2345, 3, 2, 1'b1);
    checkOutput("coinc_busy2", voice_busy[2], 1);
    checkOutput("coinc_nodone", done_with_note, 4'b0000);
    doBeat();
    doBeat();
    checkOutput("coinc_still_busy", voice_busy[2], 1);
    doBeat();
    checkOutput("coinc_expire", done_with_note[2], 1);

    doRequest(2, 3, -1, 0, 0, 0);
    doRequest(0, 0, 1, 20'h777, 4, 2);

    play_enable = 1'b0;
    doRequest(0, 0, -1, 0, 0, 0);
    doBeat();
    play_enable = 1'b1;

    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    tick();
    tick();
    doReset("reset_mid");
    play_enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (new_sample_ready) seen = 1;
      tick();
    end
    checkOutput("flushed_nsr", seen, 0);
    checkOutput("flushed_sample", sample_out, 16'h0000);

    for (int i = 0; i < 120; i++)
      applyStimulus($urandom_range(0, 9));

    dExp = busyExp();
    checkOutput("final_busy", voice_busy, dExp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
